// File: rtl/picomips_host_pkg.sv
// picomips_host_pkg: shared types and constants for the picoMips host
// sequencer.
//   pmh_state_t         sequencer states
//   PMH_CPU_RST_CYCLES  length of the CPU reset pulse, used only when
//                       PMH_CPU_RESET_EN is defined
//   PMH_HOLD_DEFAULT    default strobe phase length in cycles
//   PMH_COMPUTE_DEFAULT default compute interval in cycles
package picomips_host_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CPU_RST,
    X_HI,
    X_LO,
    Y_HI,
    Y_LO,
    R_HI,
    R_LO,
    DONE
  } pmh_state_t;

  localparam int unsigned PMH_CPU_RST_CYCLES  = 4;
  localparam int unsigned PMH_HOLD_DEFAULT    = 64;
  localparam int unsigned PMH_COMPUTE_DEFAULT = 48;

  // Timer load value for a phase of n cycles; the phase ends when the count hits 0.
  function automatic logic [7:0] pmh_load_value(input int unsigned n);
    return 8'(n - 1);
  endfunction

endpackage

// File: rtl/pmh_phase_timer.sv
// pmh_phase_timer: 8-bit loadable down-counter shared by every sequencer phase.
// Saturates at zero, so it rests at zero while the sequencer is idle.
//   Clock       system clock, rising edge
//   nReset      asynchronous, active-low reset
//   load        load load_value this cycle
//   load_value  count loaded on entry to a phase (phase length - 1)
//   value       current count
//   zero        count is zero: last cycle of the current phase
module pmh_phase_timer (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic [7:0] value,
  output logic       zero
);

  logic [7:0] count;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of the order of statements.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign value = count;
  assign zero  = (count == 8'd0);

endmodule

// File: rtl/picomips_host.sv
// picomips_host: drives the picoMips switch handshake (SW[7:0] data, SW[8]
// strobe) so the CPU runs without an operator. An (x, y) pair is loaded as two
// strobed values; after the compute interval x2 is sampled from LED, the
// strobe is toggled to obtain y2, and (x2, y2) is returned on a valid/ready
// output. LED values pass through unmodified.
//   Clock, nReset        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_ready is high only in IDLE
//   in_x, in_y           signed 8-bit operands
//   sw_data, sw_strobe   to picoMips SW[7:0] and SW[8]
//   led                  from picoMips LED
//   res_valid/res_ready  result handshake; res_x, res_y hold x2, y2
//   busy                 high in any state other than IDLE
//   cpu_nreset           to picoMips SW[9], only when PMH_CPU_RESET_EN is defined
// Optional feature macro: PMH_CPU_RESET_EN (pulses the CPU reset for
// PMH_CPU_RST_CYCLES before every transaction).
module picomips_host
  import picomips_host_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = PMH_HOLD_DEFAULT,
  parameter int unsigned COMPUTE_CYCLES = PMH_COMPUTE_DEFAULT
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_x,
  input  logic [7:0] in_y,
  output logic [7:0] sw_data,
  output logic       sw_strobe,
  input  logic [7:0] led,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_x,
  output logic [7:0] res_y,
  output logic       busy
`ifdef PMH_CPU_RESET_EN
  ,
  output logic       cpu_nreset
`endif
);

  if (HOLD_CYCLES < 4 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("picomips_host: HOLD_CYCLES must be in 4..255");
  end
  if (COMPUTE_CYCLES < 4 || COMPUTE_CYCLES > 255) begin : g_bad_compute
    $error("picomips_host: COMPUTE_CYCLES must be in 4..255");
  end

  localparam logic [7:0] HOLD_LD    = pmh_load_value(HOLD_CYCLES);
  localparam logic [7:0] COMPUTE_LD = pmh_load_value(COMPUTE_CYCLES);
`ifdef PMH_CPU_RESET_EN
  localparam logic [7:0] FIRST_LD   = pmh_load_value(PMH_CPU_RST_CYCLES);
`else
  localparam logic [7:0] FIRST_LD   = HOLD_LD;
`endif

  pmh_state_t state;
  logic [7:0] y_hold;
  logic       t_load;
  logic [7:0] t_load_value;
  logic [7:0] t_value;
  logic       t_zero;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  pmh_phase_timer u_timer (
    .Clock      (Clock),
    .nReset     (nReset),
    .load       (t_load),
    .load_value (t_load_value),
    .value      (t_value),
    .zero       (t_zero)
  );

  // Reload the timer on every phase exit that enters another timed phase.
  // NOTE: every output of this block gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    t_load       = 1'b0;
    t_load_value = HOLD_LD;
    case (state)
      IDLE: begin
        t_load       = in_valid;
        t_load_value = FIRST_LD;
      end
      CPU_RST, X_HI, X_LO, Y_LO, R_HI: t_load = t_zero;
      Y_HI: begin
        t_load       = t_zero;
        t_load_value = COMPUTE_LD;
      end
      default: t_load = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      sw_data    <= '0;
      sw_strobe  <= 1'b0;
      res_valid  <= 1'b0;
      res_x      <= '0;
      res_y      <= '0;
      y_hold     <= '0;
`ifdef PMH_CPU_RESET_EN
      cpu_nreset <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          sw_strobe <= 1'b0;
`ifdef PMH_CPU_RESET_EN
          cpu_nreset <= 1'b1;
`endif
          if (in_valid) begin
            y_hold  <= in_y;
            sw_data <= in_x;
`ifdef PMH_CPU_RESET_EN
            cpu_nreset <= 1'b0;
            state      <= CPU_RST;
`else
            sw_strobe <= 1'b1;
            state     <= X_HI;
`endif
          end
        end
`ifdef PMH_CPU_RESET_EN
        CPU_RST: if (t_zero) begin
          cpu_nreset <= 1'b1;
          sw_strobe  <= 1'b1;
          state      <= X_HI;
        end
`endif
        X_HI: if (t_zero) begin
          sw_strobe <= 1'b0;
          state     <= X_LO;
        end
        X_LO: if (t_zero) begin
          sw_data   <= y_hold;
          sw_strobe <= 1'b1;
          state     <= Y_HI;
        end
        Y_HI: if (t_zero) begin
          sw_strobe <= 1'b0;
          state     <= Y_LO;
        end
        Y_LO: if (t_zero) begin
          res_x     <= led;
          sw_strobe <= 1'b1;
          state     <= R_HI;
        end
        R_HI: if (t_zero) begin
          res_y     <= led;
          sw_strobe <= 1'b0;
          state     <= R_LO;
        end
        R_LO: if (t_zero) begin
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picomips_host.sv
// tb_picomips_host: scoreboard bench for picomips_host. A behavioural picoMips
// stand-in captures the two strobed loads and answers on LED with
// x2 = 3x/4 + y/2 + 20, y2 = -x/2 + 3y/4 - 20, a few cycles after each strobe
// edge. Expected results are hand-computed constants pushed at stimulus time;
// a monitor pops and compares on each result handshake.
module tb_picomips_host;
  import picomips_host_pkg::*;

  localparam int HOLD    = 8;
  localparam int COMPUTE = 6;
`ifdef PMH_CPU_RESET_EN
  localparam int PRE = PMH_CPU_RST_CYCLES;
`else
  localparam int PRE = 0;
`endif
  localparam int LAT = PRE + 5 * HOLD + COMPUTE;

  logic       Clock = 1'b0;
  logic       nReset;
  logic       in_valid, in_ready;
  logic [7:0] in_x, in_y;
  logic [7:0] sw_data;
  logic       sw_strobe;
  logic [7:0] led;
  logic       res_valid, res_ready;
  logic [7:0] res_x, res_y;
  logic       busy;
`ifdef PMH_CPU_RESET_EN
  logic       cpu_nreset;
`endif

  picomips_host #(.HOLD_CYCLES(HOLD), .COMPUTE_CYCLES(COMPUTE)) dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .sw_data   (sw_data),
    .sw_strobe (sw_strobe),
    .led       (led),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_x     (res_x),
    .res_y     (res_y),
    .busy      (busy)
`ifdef PMH_CPU_RESET_EN
    ,
    .cpu_nreset(cpu_nreset)
`endif
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- picoMips stand-in ----------------
  function automatic logic [7:0] cpu_x2(input logic signed [7:0] x, input logic signed [7:0] y);
    int r;
    r = (3 * int'(x)) / 4 + int'(y) / 2 + 20;
    return 8'(r);
  endfunction

  function automatic logic [7:0] cpu_y2(input logic signed [7:0] x, input logic signed [7:0] y);
    int r;
    r = -(int'(x) / 2) + (3 * int'(y)) / 4 - 20;
    return 8'(r);
  endfunction

  int         rises;
  int         dly;
  logic       prev_s;
  logic [7:0] mx, my, pend;

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      rises  <= 0;
      dly    <= 0;
      prev_s <= 1'b0;
      mx     <= '0;
      my     <= '0;
      pend   <= '0;
      led    <= 8'hA5;
    end else begin
      if (dly == 1) led <= pend;
      if (dly > 0) dly <= dly - 1;
      if (sw_strobe && !prev_s) begin
        if (rises == 0) mx <= sw_data;
        else if (rises == 1) my <= sw_data;
        else begin
          pend <= cpu_y2(mx, my);
          dly  <= 3;
        end
        rises <= rises + 1;
      end
      if (!sw_strobe && prev_s) begin
        if (rises == 2) begin
          pend <= cpu_x2(mx, my);
          dly  <= 3;
        end else if (rises == 3) begin
          rises <= 0;
          led   <= 8'h5A;
        end
      end
      prev_s <= sw_strobe;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
  } res_t;

  res_t exp_q[$];

  always @(negedge Clock) begin
    if (nReset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got x=0x%0h y=0x%0h, expected none", res_x, res_y);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("res_x", {24'd0, res_x}, {24'd0, e.x});
        check("res_y", {24'd0, res_y}, {24'd0, e.y});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] ex, input logic [7:0] ey, input bit push);
    int guard = 0;
    @(posedge Clock); #1;
    while (!in_ready && guard < 1000) begin
      @(posedge Clock); #1;
      guard++;
    end
    if (guard >= 1000) check("accept_timeout", 32'(guard), 32'd0);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    if (push) exp_q.push_back('{ex, ey});
    @(posedge Clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge Clock);
    while (busy && guard < LAT + 200) begin
      @(negedge Clock);
      guard++;
    end
    if (guard >= LAT + 200) check("idle_timeout", 32'(guard), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sw_data"},   {24'd0, sw_data}, 32'd0);
    check({tag, "_sw_strobe"}, {31'd0, sw_strobe}, 32'd0);
    check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
    check({tag, "_res_x"},     {24'd0, res_x}, 32'd0);
    check({tag, "_res_y"},     {24'd0, res_y}, 32'd0);
    check({tag, "_in_ready"},  {31'd0, in_ready}, 32'd1);
    check({tag, "_busy"},      {31'd0, busy}, 32'd0);
`ifdef PMH_CPU_RESET_EN
    check({tag, "_cpu_nreset"}, {31'd0, cpu_nreset}, 32'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int runs[$];
    int exp_runs[$];
    int run_len;
    logic run_lvl;
    int bad_x, bad_y, bad_nrst;
    logic [7:0] hold_x, hold_y;
    int bad_stable, bad_ready, bad_idle;

    nReset    = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    res_ready = 1'b1;
    repeat (3) @(negedge Clock);
    check_reset_values("reset");
    nReset = 1'b1;

    // Waveform and latency: x=40, y=20.
    @(posedge Clock); #1;
    in_valid = 1'b1;
    in_x     = 8'd40;
    in_y     = 8'd20;
    exp_q.push_back('{8'h3C, 8'hE7});
    @(posedge Clock); #1;
    in_valid = 1'b0;
    bad_x    = 0;
    bad_y    = 0;
    bad_nrst = 0;
    run_len  = 0;
    run_lvl  = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge Clock);
      if (k <= LAT) begin
        if (k == 1) begin
          run_lvl = sw_strobe;
          run_len = 1;
        end else if (sw_strobe == run_lvl) begin
          run_len++;
        end else begin
          runs.push_back(run_len);
          run_lvl = sw_strobe;
          run_len = 1;
        end
        if (k <= PRE + 2 * HOLD) begin
          if (sw_data !== 8'h28) bad_x++;
        end else if (sw_data !== 8'h14) begin
          bad_y++;
        end
`ifdef PMH_CPU_RESET_EN
        if (cpu_nreset !== (k > PMH_CPU_RST_CYCLES)) bad_nrst++;
`endif
      end
      if (k == 1) check("first_strobe_level", {31'd0, sw_strobe}, (PRE == 0) ? 32'd1 : 32'd0);
      if (k == LAT) check("res_valid_before_latency", {31'd0, res_valid}, 32'd0);
      if (k == LAT + 1) check("res_valid_at_latency", {31'd0, res_valid}, 32'd1);
    end
    runs.push_back(run_len);
    if (PRE > 0) exp_runs.push_back(PRE);
    exp_runs.push_back(HOLD);
    exp_runs.push_back(HOLD);
    exp_runs.push_back(HOLD);
    exp_runs.push_back(COMPUTE);
    exp_runs.push_back(HOLD);
    exp_runs.push_back(HOLD);
    check("strobe_run_count", 32'(runs.size()), 32'(exp_runs.size()));
    for (int i = 0; i < exp_runs.size() && i < runs.size(); i++)
      check($sformatf("strobe_run_%0d", i), 32'(runs[i]), 32'(exp_runs[i]));
    check("sw_data_x_bad_cycles", 32'(bad_x), 32'd0);
    check("sw_data_y_bad_cycles", 32'(bad_y), 32'd0);
    check("cpu_nreset_bad_cycles", 32'(bad_nrst), 32'd0);
    wait_idle();
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Zero operands and negative operand.
    send(8'd0, 8'd0, 8'h14, 8'hEC, 1'b1);
    wait_idle();
    send(8'hD8, 8'd0, 8'hF6, 8'h00, 1'b1);
    wait_idle();

    // Backpressure: hold res_ready low in DONE for 100 cycles.
    res_ready = 1'b0;
    send(8'd40, 8'd20, 8'h3C, 8'hE7, 1'b1);
    begin
      int guard = 0;
      @(negedge Clock);
      while (!res_valid && guard < LAT + 200) begin
        @(negedge Clock);
        guard++;
      end
      check("bp_res_valid_seen", {31'd0, res_valid}, 32'd1);
    end
    hold_x     = res_x;
    hold_y     = res_y;
    bad_stable = 0;
    bad_ready  = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge Clock); #1;
      in_valid = (i == 50);
      in_x     = 8'h11;
      in_y     = 8'h22;
      @(negedge Clock);
      if (!res_valid || res_x !== hold_x || res_y !== hold_y) bad_stable++;
      if (in_ready !== 1'b0 || busy !== 1'b1) bad_ready++;
    end
    check("bp_result_unstable_cycles", 32'(bad_stable), 32'd0);
    check("bp_in_ready_high_cycles", 32'(bad_ready), 32'd0);
    check("bp_held_res_x", {24'd0, hold_x}, 32'h3C);
    check("bp_held_res_y", {24'd0, hold_y}, 32'hE7);
    @(posedge Clock); #1;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    check("bp_release_busy", {31'd0, busy}, 32'd0);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_res_valid", {31'd0, res_valid}, 32'd0);
    bad_idle = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      if (busy !== 1'b0 || sw_strobe !== 1'b0) bad_idle++;
    end
    check("bp_pulse_not_accepted", 32'(bad_idle), 32'd0);

    // Reset in the middle of Y_HI: aborted, no result.
    send(8'd40, 8'd20, 8'h00, 8'h00, 1'b0);
    repeat (PRE + 2 * HOLD + 3) @(negedge Clock);
    check("pre_reset_in_y_hi", {31'd0, sw_strobe}, 32'd1);
    nReset = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge Clock);
    nReset = 1'b1;
    @(negedge Clock);
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    bad_idle = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge Clock);
      if (res_valid !== 1'b0 || sw_strobe !== 1'b0 || busy !== 1'b0) bad_idle++;
    end
    check("post_reset_quiet_cycles", 32'(bad_idle), 32'd0);

    // End-to-end again after the abort.
    send(8'd0, 8'd0, 8'h14, 8'hEC, 1'b1);
    wait_idle();
    @(negedge Clock);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/picomips_host.md
Name: picomips_host

Overview:
- Host-side sequencer that drives the picoMips switch handshake (SW[7:0] data, SW[8] strobe) and captures the two results from the picoMips LED bus.
- Accepts an (x, y) coordinate pair on a valid/ready input and presents it to the CPU as two strobed loads. After a compute interval it samples x2 from LED, then toggles the strobe to obtain y2, and returns (x2, y2) on a valid/ready output.
- Used in simulation benches and on-board self-test, so the CPU runs with no operator at the switches.

Parameters:
- HOLD_CYCLES, 64, Clock cycles each strobe phase (high or low) is held. Must exceed the CPU wait-loop period. Legal range 4..255.
- COMPUTE_CYCLES, 48, Cycles the strobe stays low after the y load before LED is sampled as x2. Legal range 4..255.

Ports:
- Clock       input   1  system clock, rising edge
- nReset      input   1  asynchronous, active-low reset
- in_valid    input   1  (x, y) pair available
- in_ready    output  1  host can accept a pair (IDLE only)
- in_x        input   8  x1 operand, signed two's complement
- in_y        input   8  y1 operand, signed two's complement
- sw_data     output  8  drives picoMips SW[7:0]
- sw_strobe   output  1  drives picoMips SW[8]
- led         input   8  from picoMips LED
- res_valid   output  1  result pair held valid
- res_ready   input   1  result consumer ready
- res_x       output  8  captured x2
- res_y       output  8  captured y2
- busy        output  1  high in any state other than IDLE

Behaviour:
- Reset values: sw_data=0, sw_strobe=0, res_valid=0, res_x=0, res_y=0, in_ready=1 (combinational from IDLE), busy=0, phase counter=0, state=IDLE.
- Reset mid-transaction aborts immediately; no partial result is emitted.
- All outputs are registered except in_ready and busy, which decode from state.
- Phase counter: down-counter loaded with N-1 on phase entry; the phase ends on the cycle the count reaches 0. Each phase therefore lasts exactly N cycles.
- States and transitions:
  - IDLE: sw_strobe=0. On in_valid&&in_ready, latch in_y internally, set sw_data<=in_x, load HOLD, go X_HI.
  - X_HI: sw_strobe=1 for HOLD cycles, then X_LO.
  - X_LO: sw_strobe=0 for HOLD cycles. On exit set sw_data<=latched y, go Y_HI.
  - Y_HI: sw_strobe=1 for HOLD cycles, then Y_LO.
  - Y_LO: sw_strobe=0 for COMPUTE cycles. On the final cycle set res_x<=led, go R_HI.
  - R_HI: sw_strobe=1 for HOLD cycles. On the final cycle set res_y<=led, go R_LO.
  - R_LO: sw_strobe=0 for HOLD cycles, then DONE with res_valid<=1.
  - DONE: hold res_valid, res_x and res_y stable until res_ready. On res_valid&&res_ready, clear res_valid and go IDLE.
- sw_data stays stable through each strobe edge; it changes only when sw_strobe=0.
- A transaction takes 5*HOLD+COMPUTE cycles from accept to res_valid.
- Back-to-back operation: in_valid high in DONE is not accepted (in_ready=0). The earliest next accept is the cycle after the DONE→IDLE transition.
- res_ready while not in DONE is ignored.
- The LED values are passed through unmodified. This block performs no arithmetic on the results.
- Out-of-range parameters cause an elaboration-time error via an initial assertion.

Optional Feature:
- Macro: PMH_CPU_RESET_EN.
- When defined:
  - Adds output cpu_nreset (1 bit, reset value 0), which drives picoMips SW[9].
  - In IDLE, cpu_nreset=1 once out of reset.
  - On accept, the FSM enters state CPU_RST, holding cpu_nreset=0 for 4 cycles with sw_strobe=0, then enters X_HI. This resynchronises the CPU program counter to instruction 0 for every transaction.
  - Transaction latency grows by 4 cycles.
- When undefined: no cpu_nreset port and no CPU_RST state. The integrator ties SW[9] high, and the CPU runs free-looping.

Decomposition:
- Package picomips_host_pkg:
  - state enum typedef pmh_state_t (IDLE, CPU_RST, X_HI, X_LO, Y_HI, Y_LO, R_HI, R_LO, DONE)
  - constant PMH_CPU_RST_CYCLES=4
  - default HOLD/COMPUTE constants
- Sub-module pmh_phase_timer: 8-bit loadable down-counter with load, value and zero outputs. It is instantiated once and shared by all phases.

Test Plan:
- Reset and idle: nReset low mid-Y_HI, then released → all outputs at reset values, state IDLE, in_ready=1, no res_valid.
- Strobe waveform: accept x=40, y=20 with HOLD=8, COMPUTE=6 → sw_strobe high/low runs of exactly 8,8,8,6,8,8 cycles. sw_data=0x28 during X phases, 0x14 from Y_HI onward. res_valid asserted 46 cycles after accept.
- End-to-end with picomips instance (HOLD=64): x=40, y=20 → res_x=60 (0x3C), res_y=-25 (0xE7). Then x=0, y=0 → res_x=20, res_y=-20 (0xEC).
- Backpressure: hold res_ready=0 for 100 cycles in DONE → res_valid, res_x and res_y stay stable, in_ready=0, and an in_valid pulse is not accepted. Then res_ready=1 → IDLE next cycle.
- Negative operands: x=-40 (0xD8), y=0 → res_x=-10 (0xF6), res_y=0 (0x00).
- With PMH_CPU_RESET_EN: cpu_nreset low for exactly 4 cycles after accept, then X_HI. Total latency is 4 cycles longer, and end-to-end results match the results scenario.
